param_sum_sequencer: RTL and testbench

- Controller that sequences a single shared adder to build one parameter-offset sum per frame.
- Each frame: accumulator seeded with constant P, then COUNT operands accepted over a valid/ready stream, then one result presented on a valid/ready output.
- Sits between an operand source and a result consumer. Replaces fixed constant-sum submodules wherever operands arrive at run time.

---
 rtl/param_sum_sequencer.sv | 97 +++++++++
 tb/tb_param_sum_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/param_sum_sequencer.sv
// ============================================================================
// Module   : param_sum_sequencer
// Brief    : Per-frame sum of COUNT streamed operands offset by constant P,
//            built on one shared adder and returned on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_sum_sequencer #(
    parameter int        WIDTH = 32,
    parameter int signed P     = 1,
    parameter int        COUNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       op_cnt
);

    localparam logic [WIDTH-1:0] C_SEED = WIDTH'(P);
    localparam logic [7:0]       C_LAST = 8'(COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] w_sum;
    logic             w_beat;
    logic             w_last;

    assign w_sum  = r_acc + in_data;
    assign w_beat = (r_state == ST_ACCUM) && in_valid;
    assign w_last = w_beat && (r_cnt == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)     w_next = ST_ACCUM;
            ST_ACCUM: if (w_last)    w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // The result register is loaded only on the final beat, so it holds the
    // previous frame's sum through IDLE and the next ACCUM phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_out <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_acc <= C_SEED;
                r_cnt <= '0;
            end
            if (w_beat) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_last) begin
                r_out <= w_sum;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_out;
    assign op_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_param_sum_sequencer.sv
// ============================================================================
// Module   : tb_param_sum_sequencer
// Brief    : Directed vector bench for param_sum_sequencer (three configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_sum_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b, start_c;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         out_ready;

    logic         busy_a, in_ready_a, out_valid_a;
    logic         busy_b, in_ready_b, out_valid_b;
    logic         busy_c, in_ready_c, out_valid_c;
    logic [W-1:0] out_data_a, out_data_b, out_data_c;
    logic [7:0]   op_cnt_a, op_cnt_b, op_cnt_c;

    logic [42:0]  st_a, st_b, st_c;
    assign st_a = {busy_a, in_ready_a, out_valid_a, op_cnt_a, out_data_a};
    assign st_b = {busy_b, in_ready_b, out_valid_b, op_cnt_b, out_data_b};
    assign st_c = {busy_c, in_ready_c, out_valid_c, op_cnt_c, out_data_c};

    param_sum_sequencer #(.WIDTH(W), .P(1), .COUNT(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .op_cnt(op_cnt_a)
    );

    param_sum_sequencer #(.WIDTH(W), .P(-1), .COUNT(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .op_cnt(op_cnt_b)
    );

    param_sum_sequencer #(.WIDTH(W), .P(1), .COUNT(4)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_c),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready),
        .op_cnt(op_cnt_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic [42:0]  exp;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl [20];

    function automatic logic [42:0] pk(input logic b, input logic ir, input logic ov,
                                       input logic [7:0] cnt, input logic [W-1:0] od);
        return {b, ir, ov, cnt, od};
    endfunction

    function automatic vec_t mk(input logic s, input logic iv, input logic [W-1:0] d,
                                input logic ordy, input logic [42:0] exp);
        vec_t v;
        v.start = s; v.iv = iv; v.d = d; v.ordy = ordy; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [42:0] act, input logic [42:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got busy=%b in_ready=%b out_valid=%b op_cnt=%0d out_data=%h, expected busy=%b in_ready=%b out_valid=%b op_cnt=%0d out_data=%h",
                     nm, act[42], act[41], act[40], act[39:32], act[31:0],
                     exp[42], exp[41], exp[40], exp[39:32], exp[31:0]);
        end
    endtask

    task automatic drive(input logic sa, input logic sb, input logic sc,
                         input logic iv, input logic [W-1:0] d, input logic ordy);
        start_a = sa; start_b = sb; start_c = sc;
        in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, '0, 0);
        rst = 1'b1;
        #1;
        chk("reset_a", st_a, pk(0, 0, 0, 8'd0, 32'h0));
        chk("reset_b", st_b, pk(0, 0, 0, 8'd0, 32'h0));
        chk("reset_c", st_c, pk(0, 0, 0, 8'd0, 32'h0));
        step();
        rst = 1'b0;

        // P=1, COUNT=2: basic frame, wrap-around, handshake-cycle start, back-pressure
        tbl[0]  = mk(1, 0, 32'h0,        0, pk(1, 1, 0, 8'd0, 32'd0));
        tbl[1]  = mk(0, 1, 32'd1,        0, pk(1, 1, 0, 8'd1, 32'd0));
        tbl[2]  = mk(0, 1, 32'd1,        0, pk(1, 0, 1, 8'd2, 32'd3));
        tbl[3]  = mk(0, 0, 32'h0,        1, pk(0, 0, 0, 8'd2, 32'd3));
        tbl[4]  = mk(1, 0, 32'h0,        0, pk(1, 1, 0, 8'd0, 32'd3));
        tbl[5]  = mk(0, 1, 32'hFFFFFFFF, 0, pk(1, 1, 0, 8'd1, 32'd3));
        tbl[6]  = mk(0, 1, 32'h0,        0, pk(1, 0, 1, 8'd2, 32'd0));
        tbl[7]  = mk(1, 0, 32'h0,        1, pk(0, 0, 0, 8'd2, 32'd0));
        tbl[8]  = mk(0, 0, 32'h0,        0, pk(0, 0, 0, 8'd2, 32'd0));
        tbl[9]  = mk(1, 0, 32'h0,        0, pk(1, 1, 0, 8'd0, 32'd0));
        tbl[10] = mk(0, 0, 32'h0,        0, pk(1, 1, 0, 8'd0, 32'd0));
        tbl[11] = mk(0, 1, 32'd5,        0, pk(1, 1, 0, 8'd1, 32'd0));
        tbl[12] = mk(0, 1, 32'd7,        0, pk(1, 0, 1, 8'd2, 32'd13));
        for (int i = 13; i < 18; i++)
            tbl[i] = mk(1, 1, 32'd9,     0, pk(1, 0, 1, 8'd2, 32'd13));
        tbl[18] = mk(0, 0, 32'h0,        1, pk(0, 0, 0, 8'd2, 32'd13));
        tbl[19] = mk(0, 0, 32'h0,        0, pk(0, 0, 0, 8'd2, 32'd13));

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].start, 0, 0, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            step();
            chk($sformatf("tbl_a[%0d]", i), st_a, tbl[i].exp);
        end

        // P=-1, COUNT=1: a single beat completes the frame
        drive(0, 1, 0, 0, '0, 0);
        step();
        chk("b_start", st_b, pk(1, 1, 0, 8'd0, 32'd0));
        drive(0, 0, 0, 1, 32'd0, 0);
        step();
        chk("b_done", st_b, pk(1, 0, 1, 8'd1, 32'hFFFFFFFF));
        drive(0, 0, 0, 0, '0, 1);
        step();
        chk("b_idle", st_b, pk(0, 0, 0, 8'd1, 32'hFFFFFFFF));

        // P=1, COUNT=4: beats 2..5 with growing gaps, stray start mid-frame
        drive(0, 0, 1, 0, '0, 0);
        step();
        chk("c_start", st_c, pk(1, 1, 0, 8'd0, 32'd0));
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) begin
                drive(0, 0, (i == 2), 0, 32'd77, 0);
                step();
                chk($sformatf("c_gap[%0d.%0d]", i, g), st_c,
                    pk(1, 1, 0, 8'(i), 32'd0));
            end
            drive(0, 0, 0, 1, 32'(i + 2), 0);
            step();
            if (i < 3)
                chk($sformatf("c_beat[%0d]", i), st_c, pk(1, 1, 0, 8'(i + 1), 32'd0));
            else
                chk("c_done", st_c, pk(1, 0, 1, 8'd4, 32'd15));
        end
        drive(0, 0, 0, 0, '0, 1);
        step();
        chk("c_idle", st_c, pk(0, 0, 0, 8'd4, 32'd15));
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 32'd1, 1);
            step();
            chk($sformatf("c_no_second_result[%0d]", k), st_c,
                pk(0, 0, 0, 8'd4, 32'd15));
        end

        // Async reset mid-frame on config A, then a clean frame
        drive(1, 0, 0, 0, '0, 0);
        step();
        drive(0, 0, 0, 1, 32'd7, 0);
        step();
        chk("a_pre_reset", st_a, pk(1, 1, 0, 8'd1, 32'd13));
        drive(0, 0, 0, 0, '0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("a_async_reset", st_a, pk(0, 0, 0, 8'd0, 32'd0));
        step();
        rst = 1'b0;
        drive(1, 0, 0, 0, '0, 0);
        step();
        drive(0, 0, 0, 1, 32'd4, 0);
        step();
        drive(0, 0, 0, 1, 32'd5, 0);
        step();
        chk("a_after_reset", st_a, pk(1, 0, 1, 8'd2, 32'd10));
        drive(0, 0, 0, 0, '0, 1);
        step();
        chk("a_after_reset_idle", st_a, pk(0, 0, 0, 8'd2, 32'd10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
